eros_clock_gate_ctrl: RTL and testbench

EROS_CLOCK_GATE_CTRL -- requirements
Module: eros_clock_gate_ctrl

---
 rtl/eros_clock_gate_ctrl.sv | 118 +++++++++++
 tb/tb_eros_clock_gate_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/eros_clock_gate_ctrl.sv
// Per-channel clock gating controller: OFF/WAKE/RUN/IDLE/GATED FSM with idle
// auto-gating, and a low-transparent latch gate per channel.
module eros_clock_gate_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic [NCH-1:0]        sw_en_i,
  input  logic [NCH-1:0]        auto_en_i,
  input  logic [NCH-1:0]        busy_i,
  input  logic [NCH*IDLE_W-1:0] idle_thr_i,
  output logic [NCH-1:0]        clk_o,
  output logic [NCH-1:0]        ready_o,
  output logic [NCH-1:0]        gated_o,
  output logic                  all_gated_o
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_RUN,
    ST_IDLE,
    ST_GATED
  } state_t;

  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYC - 1);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t            state_q, state_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [IDLE_W-1:0] icnt_q, icnt_d;
    logic [IDLE_W-1:0] thr;
    logic              en_q, rdy_q, gtd_q, lat_q;

    assign thr = idle_thr_i[c*IDLE_W +: IDLE_W];

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      if (!sw_en_i[c]) begin
        state_d = ST_OFF;
        wcnt_d  = '0;
        icnt_d  = '0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            state_d = ST_WAKE;
            wcnt_d  = '0;
          end
          ST_WAKE: begin
            if (wcnt_q == WAKE_LAST) state_d = ST_RUN;
            else                     wcnt_d  = wcnt_q + 8'd1;
          end
          ST_RUN: begin
            if (auto_en_i[c] && !busy_i[c]) begin
              state_d = ST_IDLE;
              icnt_d  = '0;
            end
          end
          ST_IDLE: begin
            // Compare before increment so the counter can never wrap.
            if (busy_i[c] || !auto_en_i[c]) begin
              state_d = ST_RUN;
              icnt_d  = '0;
            end else if (icnt_q == thr) begin
              state_d = ST_GATED;
            end else begin
              icnt_d = icnt_q + 1'b1;
            end
          end
          ST_GATED: begin
            if (busy_i[c] || !auto_en_i[c]) begin
              state_d = ST_WAKE;
              wcnt_d  = '0;
            end
          end
          default: state_d = ST_OFF;
        endcase
      end
    end

    // Enable and status flops are loaded from the next state so they track
    // the FSM with no extra cycle of lag and no input-to-output path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_OFF;
        wcnt_q  <= '0;
        icnt_q  <= '0;
        en_q    <= 1'b0;
        rdy_q   <= 1'b0;
        gtd_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        icnt_q  <= icnt_d;
        en_q    <= (state_d == ST_WAKE) || (state_d == ST_RUN) || (state_d == ST_IDLE);
        rdy_q   <= (state_d == ST_RUN) || (state_d == ST_IDLE);
        gtd_q   <= (state_d == ST_OFF) || (state_d == ST_GATED);
      end
    end

    always_latch begin
      if (!rst_ni)     lat_q <= 1'b0;
      else if (!clk_i) lat_q <= en_q | test_en_i;
    end

    assign clk_o[c]   = clk_i & (lat_q | (test_en_i & ~rst_ni));
    assign ready_o[c] = rdy_q;
    assign gated_o[c] = gtd_q;
  end

  assign all_gated_o = &gated_o;

endmodule

// File: tb/tb_eros_clock_gate_ctrl.sv
// Directed bench for eros_clock_gate_ctrl (NCH=4, IDLE_W=8, WAKE_CYC=2).
module tb_eros_clock_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        test_en;
  logic [3:0]  sw_en;
  logic [3:0]  auto_en;
  logic [3:0]  busy;
  logic [31:0] idle_thr;
  logic [3:0]  clk_g;
  logic [3:0]  ready;
  logic [3:0]  gated;
  logic        all_gated;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  eros_clock_gate_ctrl #(
    .NCH      (4),
    .IDLE_W   (8),
    .WAKE_CYC (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_en_i   (test_en),
    .sw_en_i     (sw_en),
    .auto_en_i   (auto_en),
    .busy_i      (busy),
    .idle_thr_i  (idle_thr),
    .clk_o       (clk_g),
    .ready_o     (ready),
    .gated_o     (gated),
    .all_gated_o (all_gated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge (inside the high phase).
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    test_en  = 1'b0;
    sw_en    = '0;
    auto_en  = '0;
    busy     = '0;
    idle_thr = {8'd0, 8'd0, 8'd0, 8'd3};

    // Reset state
    step(1);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_gated", 32'(gated), 32'hF);
    chk("rst_allg", 32'(all_gated), 32'h1);
    chk("rst_clk", 32'(clk_g), 32'h0);
    test_en = 1'b1;
    step(1);
    chk("rst_test_clk", 32'(clk_g), 32'hF);
    test_en = 1'b0;
    rst_n   = 1'b1;
    step(1);
    chk("post_rst_clk", 32'(clk_g), 32'h0);

    // Wake-up of ch0
    sw_en = 4'b0001;
    step(1);
    chk("wake_k_clk", 32'(clk_g), 32'h0);
    chk("wake_k_ready", 32'(ready), 32'h0);
    step(1);
    chk("wake_k1_clk", 32'(clk_g), 32'h1);
    chk("wake_k1_ready", 32'(ready), 32'h0);
    chk("wake_k1_gated", 32'(gated), 32'hE);
    step(1);
    chk("wake_k2_ready", 32'(ready), 32'h1);
    chk("wake_k2_clk", 32'(clk_g), 32'h1);

    // Auto-gate ch0, thr=3
    auto_en = 4'b0001;
    step(1);
    chk("ag_t_ready", 32'(ready), 32'h1);
    chk("ag_t_gated", 32'(gated), 32'hE);
    step(3);
    chk("ag_t3_clk", 32'(clk_g), 32'h1);
    chk("ag_t3_gated", 32'(gated), 32'hE);
    step(1);
    chk("ag_t4_gated", 32'(gated), 32'hF);
    chk("ag_t4_ready", 32'(ready), 32'h0);
    chk("ag_t4_allg", 32'(all_gated), 32'h1);
    step(1);
    chk("ag_t5_clk", 32'(clk_g), 32'h0);

    // Re-wake from GATED on busy
    busy = 4'b0001;
    step(1);
    chk("rw_w_gated", 32'(gated), 32'hE);
    chk("rw_w_clk", 32'(clk_g), 32'h0);
    step(1);
    chk("rw_w1_clk", 32'(clk_g), 32'h1);
    chk("rw_w1_ready", 32'(ready), 32'h0);
    step(1);
    chk("rw_w2_ready", 32'(ready), 32'h1);

    // Abort idle at count 2, then full idle period again
    busy = 4'b0000;
    step(3);
    busy = 4'b0001;
    step(1);
    chk("ab_run_ready", 32'(ready), 32'h1);
    step(2);
    chk("ab_nogate", 32'(gated), 32'hE);
    busy = 4'b0000;
    step(4);
    chk("ab_t3_gated", 32'(gated), 32'hE);
    step(1);
    chk("ab_t4_gated", 32'(gated), 32'hF);

    // Re-wake then software off
    busy = 4'b0001;
    step(1);
    sw_en = 4'b0000;
    step(1);
    chk("off_w1_gated", 32'(gated), 32'hF);
    step(1);
    chk("off_w2_clk", 32'(clk_g), 32'h0);
    chk("off_w2_ready", 32'(ready), 32'h0);

    // ch1 with threshold 0, ch0 kept off
    busy     = 4'b0000;
    idle_thr = {8'd0, 8'd0, 8'd0, 8'd3};
    sw_en    = 4'b0010;
    auto_en  = 4'b0010;
    step(3);
    chk("t0_run_ready", 32'(ready), 32'h2);
    chk("t0_run_clk", 32'(clk_g), 32'h2);
    step(1);
    chk("t0_idle_gated", 32'(gated), 32'hD);
    step(1);
    chk("t0_gated", 32'(gated), 32'hF);
    chk("t0_ready", 32'(ready), 32'h0);

    // Test override with all channels off
    sw_en   = 4'b0000;
    auto_en = 4'b0000;
    step(1);
    test_en = 1'b1;
    step(1);
    chk("te_clk", 32'(clk_g), 32'hF);
    chk("te_gated", 32'(gated), 32'hF);
    chk("te_ready", 32'(ready), 32'h0);
    test_en = 1'b0;
    step(1);
    chk("te_off_clk", 32'(clk_g), 32'h0);

    // Async reset with all channels running
    sw_en = 4'b1111;
    step(3);
    chk("ar_run_ready", 32'(ready), 32'hF);
    chk("ar_run_allg", 32'(all_gated), 32'h0);
    chk("ar_run_clk", 32'(clk_g), 32'hF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", 32'(ready), 32'h0);
    chk("ar_gated", 32'(gated), 32'hF);
    chk("ar_allg", 32'(all_gated), 32'h1);
    chk("ar_clk", 32'(clk_g), 32'h0);
    step(1);
    chk("ar_clk_next", 32'(clk_g), 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("ar_rel_gated", 32'(gated), 32'h0);
    chk("ar_rel_ready", 32'(ready), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
